// File: rtl/oam_dma.sv
// oam_dma: NES sprite DMA; snoops $4014 writes, halts the CPU and copies one 256-byte page into OAMDATA.
// Ports: clk/reset (sync, active-high); cpu_addr_in/cpu_data_in/cpu_WE snoop the CPU bus;
// bus_data_in is same-cycle read data; cpu_halt/dma_active flag bus ownership;
// bus_addr_out/bus_data_out/bus_WE drive the system bus while halted.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_halt,
  output logic [15:0] bus_addr_out,
  output logic [7:0]  bus_data_out,
  output logic        bus_WE,
  output logic        dma_active
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nx;
  logic put_cycle;
  logic [7:0] page, index, latch;
  logic trig, last;
  assign trig = cpu_WE && cpu_addr_in == DMA_REG_ADDR;
  assign last = index == 8'(XFER_LEN - 1);
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      put_cycle <= 1'b0;
      page      <= 8'h00;
      index     <= 8'h00;
      latch     <= 8'h00;
    end else begin
      state     <= state_nx;
      put_cycle <= ~put_cycle;
      if (state == IDLE && trig) begin
        page  <= cpu_data_in;
        index <= 8'h00;
      end
      if (state == READ) latch <= bus_data_in;
      if (state == WRITE) index <= index + 8'd1;
    end
  // HALT goes straight to READ only when the following cycle is a get cycle
  always_comb begin
    state_nx     = state == IDLE  ? (trig ? HALT : IDLE) :
                   state == HALT  ? (put_cycle ? READ : ALIGN) :
                   state == ALIGN ? READ :
                   state == READ  ? WRITE :
                   last           ? IDLE : READ;
    dma_active   = state != IDLE;
    cpu_halt     = dma_active;
    bus_WE       = state == WRITE;
    bus_addr_out = state == READ ? {page, index} : bus_WE ? OAMDATA_ADDR : 16'h0000;
    bus_data_out = bus_WE ? latch : 8'h00;
  end
  always_ff @(posedge clk)
    if (!reset) assert ((state != READ || !put_cycle) && (state != WRITE || put_cycle));
endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_WE = 1'b0;
  logic [7:0]  bus_data_in;
  logic [7:0]  key = 8'hA5;
  logic        cpu_halt, bus_WE, dma_active;
  logic [15:0] bus_addr_out;
  logic [7:0]  bus_data_out;
  int passed = 0, total = 0, cyc = 0;
  int halt_n, rd_n, wr_n, bad, bad_idle = 0, first_rd_cyc, last_wr_cyc;
  int trig_cyc, end_cyc;
  logic [15:0] first_rd, last_rd;
  logic [7:0]  exp_page;
  logic        noise = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
    logic        halt;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // memory model: every byte is its low address byte xor key
  assign bus_data_in = bus_addr_out[7:0] ^ key;

  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
    .cpu_WE(cpu_WE), .bus_data_in(bus_data_in), .cpu_halt(cpu_halt),
    .bus_addr_out(bus_addr_out), .bus_data_out(bus_data_out), .bus_WE(bus_WE),
    .dma_active(dma_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // records one bus cycle against the transfer model: read n is {page,n} on an even cycle,
  // write n is n^key to $2004 on an odd cycle, and the bus is quiet whenever the CPU runs
  task automatic observe();
    if (reset) return;
    if (!cpu_halt) begin
      if (bus_WE || bus_addr_out != 16'h0 || bus_data_out != 8'h0 || dma_active) bad_idle++;
    end else if (!dma_active) bad++;
    else if (bus_WE) begin
      if (bus_addr_out !== 16'h2004 || bus_data_out !== (wr_n[7:0] ^ key) || cyc[0] !== 1'b1) bad++;
      last_wr_cyc = cyc;
      wr_n++;
    end else if (bus_addr_out != 16'h0) begin
      if (bus_addr_out !== {exp_page, rd_n[7:0]} || cyc[0] !== 1'b0) bad++;
      if (rd_n == 0) begin
        first_rd = bus_addr_out;
        first_rd_cyc = cyc;
      end
      last_rd = bus_addr_out;
      rd_n++;
    end
    if (cpu_halt) halt_n++;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc = reset ? 0 : cyc + 1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    cpu_addr_in = a;
    cpu_WE = w;
    cpu_data_in = d;
  endtask

  task automatic run(input logic [7:0] pg, input int inj_at, input int rst_at);
    halt_n = 0; rd_n = 0; wr_n = 0; bad = 0;
    first_rd = 16'h0; last_rd = 16'h0; first_rd_cyc = -1; last_wr_cyc = -1;
    exp_page = pg;
    trig_cyc = cyc;
    end_cyc = -1;
    drive(16'h4014, 1'b1, pg);
    tick();
    drive(16'h0, 1'b0, 8'h0);
    for (int n = 0; n < 700 && cpu_halt; n++) begin
      if (rst_at >= 0 && wr_n == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(16'h0, 1'b0, 8'h0);
        chk("reset halt", 32'(cpu_halt), 32'd0);
        chk("reset we", 32'(bus_WE), 32'd0);
        chk("reset addr", 32'(bus_addr_out), 32'd0);
        chk("reset writes done", 32'(wr_n), 32'(rst_at));
        return;
      end
      if (wr_n == inj_at) drive(16'h4014, 1'b1, ~pg);
      else if (noise) drive(16'($urandom), 1'($urandom), 8'($urandom));
      else drive(16'h0, 1'b0, 8'h0);
      tick();
    end
    drive(16'h0, 1'b0, 8'h0);
    if (!cpu_halt) end_cyc = cyc;
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] pg);
    int even = (trig_cyc % 2 == 0) ? 1 : 0;
    chk({tag, " halted cycles"}, 32'(halt_n), even ? 32'd513 : 32'd514);
    chk({tag, " writes"}, 32'(wr_n), 32'd256);
    chk({tag, " reads"}, 32'(rd_n), 32'd256);
    chk({tag, " bad cycles"}, 32'(bad), 32'd0);
    chk({tag, " first read"}, 32'(first_rd), 32'({pg, 8'h00}));
    chk({tag, " last read"}, 32'(last_rd), 32'({pg, 8'hFF}));
    chk({tag, " first read cycle"}, 32'(first_rd_cyc), 32'(trig_cyc + (even ? 2 : 3)));
    chk({tag, " release cycle"}, 32'(end_cyc), 32'(last_wr_cyc + 1));
  endtask

  initial begin
    vecs = '{
      '{16'h4014, 1'b0, 8'h02, 1'b0},
      '{16'h4015, 1'b1, 8'h02, 1'b0},
      '{16'h2004, 1'b1, 8'h02, 1'b0},
      '{16'h4014, 1'b1, 8'h02, 1'b1},
      '{16'h0014, 1'b1, 8'h02, 1'b0},
      '{16'hC014, 1'b1, 8'h02, 1'b0},
      '{16'h4013, 1'b1, 8'h02, 1'b0},
      '{16'h4014, 1'b1, 8'hFF, 1'b1}
    };
    do_reset();
    chk("reset cpu_halt", 32'(cpu_halt), 32'd0);
    chk("reset dma_active", 32'(dma_active), 32'd0);
    chk("reset bus_WE", 32'(bus_WE), 32'd0);
    chk("reset bus_addr", 32'(bus_addr_out), 32'd0);
    chk("reset bus_data", 32'(bus_data_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(vecs[i].addr, vecs[i].we, vecs[i].data);
      tick();
      drive(16'h0, 1'b0, 8'h0);
      chk($sformatf("vec%0d halt", i), 32'(cpu_halt), 32'(vecs[i].halt));
      chk($sformatf("vec%0d active", i), 32'(dma_active), 32'(vecs[i].halt));
      chk($sformatf("vec%0d addr", i), 32'(bus_addr_out), 32'd0);
    end
    do_reset();
    repeat (4) tick();
    run(8'h02, -1, -1);
    check_xfer("even", 8'h02);
    do_reset();
    repeat (5) tick();
    run(8'h03, -1, -1);
    check_xfer("odd", 8'h03);
    tick();
    run(8'h04, 10, -1);
    check_xfer("retrigger", 8'h04);
    tick();
    run(8'h05, -1, 100);
    tick();
    run(8'h06, -1, -1);
    check_xfer("after reset", 8'h06);
    run(8'hFF, -1, -1);
    check_xfer("page ff", 8'hFF);
    chk("page ff idle next", 32'(cpu_halt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a = 16'($urandom);
      logic w = 1'($urandom);
      if (a == 16'h4014) w = 1'b0;
      drive(a, w, 8'($urandom));
      tick();
      drive(16'h0, 1'b0, 8'h0);
      chk($sformatf("idle noise %0d", i), 32'(cpu_halt), 32'd0);
    end
    noise = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pg = 8'($urandom_range(1, 255));
      key = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      run(pg, -1, -1);
      check_xfer($sformatf("rand%0d", i), pg);
    end
    noise = 1'b0;
    tick();
    chk("idle bus quiet", 32'(bad_idle), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
